read_mem: RTL and testbench
===========================

Name: read_mem

Overview:
- Button-driven read sequencer for the demo RAM; the read-side counterpart of the button-driven RAM writer.
- Debounce-free synchronises three active-low buttons.
- Issues single-address reads or a full sweep to the RAM read port and absorbs the RAM read latency.
- Presents each word on a valid/ready output for the display/LED driver.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 8, RAM data width.
- RD_LAT, 1, RAM read latency in cycles (1..3) from mem_rd_en to valid mem_q.
- ADDR_A, 6, address read on btn[0] press.
- ADDR_B, 0, address read on btn[1] press.
- SWEEP_LEN, 16, number of words read on btn[2] press, starting at address 0 (1..2^ADDR_W).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- btn  in  3  raw push-buttons, active-low (0 = pressed), asynchronous to clk.
- mem_rd_en  out  1  one-cycle read strobe to RAM.
- mem_addr  out  ADDR_W  RAM read address, valid when mem_rd_en=1, otherwise holds last value.
- mem_q  in  DATA_W  RAM read data, valid RD_LAT cycles after strobe.
- out_data  out  DATA_W  captured word.
- out_addr  out  ADDR_W  address of out_data.
- out_valid  out  1  out_data/out_addr valid.
- out_ready  in  1  consumer accepts when out_valid&&out_ready.
- busy  out  1  high in any state other than IDLE.
- sweep_done  out  1  one-cycle pulse after last sweep word accepted.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; synchroniser flops set to 1 (released).
- Button path:
  - 2-flop synchroniser per bit, then a falling-edge detector (press = sync bit 1->0).
  - Press event valid for one cycle.
  - Held buttons generate no further events.
- Event acceptance:
  - Events are accepted only in IDLE; events while busy are discarded, not queued.
  - Simultaneous events: priority btn[0] > btn[1] > btn[2].
- FSM states: IDLE, ISSUE, WAIT, HOLD, DONE.
- IDLE:
  - btn[0] event -> addr=ADDR_A, single mode, -> ISSUE.
  - btn[1] event -> addr=ADDR_B, single mode.
  - btn[2] event -> addr=0, sweep mode.
- ISSUE (1 cycle): mem_rd_en=1, mem_addr=addr; load latency counter with RD_LAT; -> WAIT.
- WAIT:
  - Counter decrements each cycle.
  - On the cycle mem_q is valid (issue cycle t + RD_LAT), capture mem_q into out_data and addr into out_addr at the end of that cycle.
  - out_valid=1 from cycle t+RD_LAT+1; -> HOLD.
- HOLD:
  - out_data/out_addr stable while out_valid=1 and not accepted.
  - On acceptance: out_valid=0 next cycle.
  - Single mode -> IDLE.
  - Sweep mode with addr==SWEEP_LEN-1 -> DONE.
  - Otherwise addr+1 (wraps at 2^ADDR_W) -> ISSUE.
- DONE: sweep_done=1 for exactly one cycle -> IDLE.
- Throughput: one word per RD_LAT+2 cycles when out_ready is held 1; a single outstanding read at any time.
- mem_q is ignored outside the capture cycle.
- out_ready asserted with out_valid=0 has no effect.
- Reset mid-operation: immediate return to IDLE with outputs 0; the pending read result is dropped, and out_valid=0 is guaranteed.

Decomposition:
- Package read_mem_pkg:
  - state enum (IDLE, ISSUE, WAIT, HOLD, DONE).
  - mode enum (SINGLE, SWEEP).
  - default ADDR_A/ADDR_B constants shared with the writer demo.
- Sub-module btn_edge_sync (parameter N=3): per-bit 2-flop synchroniser plus falling-edge pulse output, reset to released state.

Test Plan:
- RAM model (RD_LAT=1) preloaded addr6=9, addr0=8; pulse btn=3'b110 with out_ready=1 -> exactly one mem_rd_en with mem_addr=6, then out_valid with out_data=9, out_addr=6; busy low afterwards.
- btn=3'b101 with out_ready=0 for 5 cycles -> out_data=8, out_addr=0 held stable while valid; single acceptance when ready rises; no second read.
- btn=3'b011, SWEEP_LEN=16, RAM[i]=i+0x10, out_ready=1 -> 16 words 0x10..0x1F in address order, one every 3 cycles; sweep_done single pulse after word 15.
- Sweep with RD_LAT=3 and random out_ready throttling -> no lost or duplicated words; mem_rd_en never asserted while out_valid=1.
- All three buttons pressed in the same cycle -> only ADDR_A read. Presses mid-sweep and a held button -> ignored, with no retrigger until release and re-press.
- rst_n asserted during WAIT of a sweep -> outputs 0 asynchronously; after release, no out_valid until a new press.

Source files
------------

// File: rtl/read_mem_pkg.sv
// Shared types and defaults for the button-driven RAM read sequencer.
package read_mem_pkg;

    // Sequencer states; every state other than IDLE reports busy.
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD,
        DONE
    } state_e;

    // SINGLE reads one word; SWEEP walks addresses from 0.
    typedef enum logic {
        SINGLE,
        SWEEP
    } mode_e;

    // Default addresses, kept equal to the ones the writer demo stores to.
    localparam int DEF_ADDR_A = 6;
    localparam int DEF_ADDR_B = 0;

    // Number of push-buttons on the demo board.
    localparam int BTN_N = 3;

endpackage

// File: rtl/read_mem_if.sv
// RAM read port plus the valid/ready word stream towards the display driver.
interface read_mem_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_q;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_valid;
    logic              out_ready;

    // Sequencer side.
    modport master (
        output mem_rd_en, mem_addr,
        input  mem_q,
        output out_data, out_addr, out_valid,
        input  out_ready
    );

    // RAM / consumer side.
    modport slave (
        input  mem_rd_en, mem_addr,
        output mem_q,
        input  out_data, out_addr, out_valid,
        output out_ready
    );
endinterface

// File: rtl/read_mem_btn_edge_sync.sv
// Per-bit 2-flop synchroniser for active-low buttons with a one-cycle
// press pulse on each synchronised 1->0 transition.
module btn_edge_sync #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] btn_n,
    output logic [N-1:0] press
);
    logic [N-1:0] meta;
    logic [N-1:0] sync;
    logic [N-1:0] prev;

    // Synchronise and keep one cycle of history; reset to the released level
    // so no phantom press appears when reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            sync <= '1;
            prev <= '1;
        end else begin
            meta <= btn_n;
            sync <= meta;
            prev <= sync;
        end
    end

    // A held button keeps sync low, so only the first cycle produces a pulse.
    assign press = prev & ~sync;

endmodule

// File: rtl/read_mem.sv
// Button-driven read sequencer: single reads at two fixed addresses or a
// sweep from address 0, absorbing the RAM read latency and presenting each
// word on a valid/ready stream.
module read_mem
    import read_mem_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int RD_LAT    = 1,
    parameter int ADDR_A    = DEF_ADDR_A,
    parameter int ADDR_B    = DEF_ADDR_B,
    parameter int SWEEP_LEN = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BTN_N-1:0] btn,
    read_mem_if.master       bus,
    output logic             busy,
    output logic             sweep_done
);
    localparam int              CNT_W = $clog2(RD_LAT + 1);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(SWEEP_LEN - 1);

    logic [BTN_N-1:0]  press;
    state_e            state, state_d;
    mode_e             mode, mode_d;
    logic [ADDR_W-1:0] addr, addr_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              cap;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;

    btn_edge_sync #(.N(BTN_N)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn),
        .press (press)
    );

    // Next-state and datapath control; presses outside IDLE are dropped.
    always_comb begin
        state_d = state;
        mode_d  = mode;
        addr_d  = addr;
        cnt_d   = cnt;
        cap     = 1'b0;
        case (state)
            IDLE: begin
                if (press[0]) begin
                    addr_d  = ADDR_W'(ADDR_A);
                    mode_d  = SINGLE;
                    state_d = ISSUE;
                end else if (press[1]) begin
                    addr_d  = ADDR_W'(ADDR_B);
                    mode_d  = SINGLE;
                    state_d = ISSUE;
                end else if (press[2]) begin
                    addr_d  = '0;
                    mode_d  = SWEEP;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(RD_LAT);
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt - CNT_W'(1);
                // Last count is the cycle mem_q carries our word.
                if (cnt == CNT_W'(1)) begin
                    cap     = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    if (mode == SINGLE) begin
                        state_d = IDLE;
                    end else if (addr == LAST) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr + ADDR_W'(1);
                        state_d = ISSUE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, address, latency counter and captured word registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mode     <= SINGLE;
            addr     <= '0;
            cnt      <= '0;
            out_data <= '0;
            out_addr <= '0;
        end else begin
            state <= state_d;
            mode  <= mode_d;
            addr  <= addr_d;
            cnt   <= cnt_d;
            if (cap) begin
                out_data <= bus.mem_q;
                out_addr <= addr;
            end
        end
    end

    // addr only changes on entry to ISSUE, so it doubles as the held mem_addr.
    assign bus.mem_rd_en = (state == ISSUE);
    assign bus.mem_addr  = addr;
    assign bus.out_valid = (state == HOLD);
    assign bus.out_data  = out_data;
    assign bus.out_addr  = out_addr;
    assign busy          = (state != IDLE);
    assign sweep_done    = (state == DONE);

endmodule

// File: tb/tb_read_mem.sv
// Bench for read_mem: two instances (read latency 1 and 3) share buttons;
// each has its own RAM model and consumer, checked against an expected
// word list built from the button presses.
module tb_read_mem;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int SWL = 16;
    localparam int A_A = 6;
    localparam int A_B = 0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } word_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] btn = 3'b111;
    logic       rdy1 = 1'b0, rdy3 = 1'b0;
    logic       busy1, busy3, done1, done3;
    bit         thr_on = 1'b0;
    bit         rec_on = 1'b0;

    read_mem_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
    read_mem_if #(.ADDR_W(AW), .DATA_W(DW)) b3 ();

    read_mem #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .ADDR_A(A_A), .ADDR_B(A_B), .SWEEP_LEN(SWL)) u_l1 (
        .clk(clk), .rst_n(rst_n), .btn(btn), .bus(b1), .busy(busy1), .sweep_done(done1));
    read_mem #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .ADDR_A(A_A), .ADDR_B(A_B), .SWEEP_LEN(SWL)) u_l3 (
        .clk(clk), .rst_n(rst_n), .btn(btn), .bus(b3), .busy(busy3), .sweep_done(done3));

    always #5 clk = ~clk;

    // RAM models: data appears RD_LAT cycles after the strobe, noise otherwise.
    logic [DW-1:0]      ram [256];
    logic [DW-1:0]      p1;
    logic [2:0][DW-1:0] p3;
    always @(posedge clk) begin
        p1 <= b1.mem_rd_en ? ram[b1.mem_addr] : DW'($urandom);
        p3 <= {p3[1:0], (b3.mem_rd_en ? ram[b3.mem_addr] : DW'($urandom))};
    end
    assign b1.mem_q     = p1;
    assign b3.mem_q     = p3[2];
    assign b1.out_ready = rdy1;
    assign b3.out_ready = rdy3;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]         vld, rdy, rd, dn;
    logic [1:0][DW-1:0] dat;
    logic [1:0][AW-1:0] adr;
    assign vld = {b3.out_valid, b1.out_valid};
    assign rdy = {rdy3, rdy1};
    assign rd  = {b3.mem_rd_en, b1.mem_rd_en};
    assign dn  = {done3, done1};
    assign dat = {b3.out_data, b1.out_data};
    assign adr = {b3.out_addr, b1.out_addr};

    int    total = 0;
    int    bad = 0;
    word_t exp_w[$];
    int    rp[2] = '{0, 0};
    int    rdcnt[2] = '{0, 0};
    int    donecnt[2] = '{0, 0};
    int    vcnt[2] = '{0, 0};
    int    last_acc[2] = '{-10, -10};
    int    acc_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Reference model: what a press accepted from idle must produce.
    task automatic expect_press(input logic [2:0] m);
        word_t w;
        if (m[0]) begin
            w.a = AW'(A_A); w.d = ram[A_A]; exp_w.push_back(w);
        end else if (m[1]) begin
            w.a = AW'(A_B); w.d = ram[A_B]; exp_w.push_back(w);
        end else if (m[2]) begin
            for (int i = 0; i < SWL; i++) begin
                w.a = AW'(i); w.d = ram[i]; exp_w.push_back(w);
            end
        end
    endtask

    // Stream monitor: scoreboard, hold stability, single outstanding read.
    initial begin
        logic [1:0]         hp;
        logic [1:0][DW-1:0] pd;
        logic [1:0][AW-1:0] pa;
        hp = '0; pd = '0; pa = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hp = '0;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (rd[k]) begin
                        rdcnt[k]++;
                        chk("rd_while_valid", 32'(vld[k]), 0);
                    end
                    if (vld[k]) vcnt[k]++;
                    if (hp[k]) begin
                        chk("hold_valid", 32'(vld[k]), 1);
                        chk("hold_data", 32'(dat[k]), 32'(pd[k]));
                        chk("hold_addr", 32'(adr[k]), 32'(pa[k]));
                    end
                    if (vld[k] && rdy[k]) begin
                        if (rp[k] < exp_w.size()) begin
                            chk("word_addr", 32'(adr[k]), 32'(exp_w[rp[k]].a));
                            chk("word_data", 32'(dat[k]), 32'(exp_w[rp[k]].d));
                            rp[k]++;
                        end else begin
                            chk("extra_word", 32'(rp[k] + 1), 32'(exp_w.size()));
                        end
                        last_acc[k] = cyc;
                        if (k == 0 && rec_on) acc_q.push_back(cyc);
                    end
                    if (dn[k]) begin
                        donecnt[k]++;
                        chk("done_timing", 32'(cyc), 32'(last_acc[k] + 1));
                    end
                    hp[k] = vld[k] & ~rdy[k];
                    pd[k] = dat[k];
                    pa[k] = adr[k];
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (thr_on) rdy3 = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic press(input logic [2:0] m);
        btn = ~m;
        tick(4);
        btn = 3'b111;
        tick(3);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        tick(4);
        while ((busy1 || busy3) && n < budget) begin
            tick(1);
            n++;
        end
        if (busy1 || busy3) chk("idle_timeout", 32'({busy3, busy1}), 0);
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_vld"},   32'(vld), 0);
        chk({tag, "_rd"},    32'(rd), 0);
        chk({tag, "_busy"},  32'({busy3, busy1}), 0);
        chk({tag, "_done"},  32'(dn), 0);
        chk({tag, "_data"},  32'(dat), 0);
        chk({tag, "_oaddr"}, 32'(adr), 0);
        chk({tag, "_maddr"}, 32'({b3.mem_addr, b1.mem_addr}), 0);
    endtask

    task automatic chk_pending();
        chk("pending_l1", 32'(rp[0]), 32'(exp_w.size()));
        chk("pending_l3", 32'(rp[1]), 32'(exp_w.size()));
    endtask

    initial begin
        int r0[2];
        int d0[2];
        int v0[2];
        int n;
        for (int i = 0; i < 256; i++) ram[i] = DW'(i + 'h10);

        // reset state
        tick(2);
        chk_outs_zero("rst");
        rst_n = 1'b1;
        tick(3);

        // single read of ADDR_A, consumer always ready
        ram[6] = 8'h09; ram[0] = 8'h08;
        rdy1 = 1'b1; rdy3 = 1'b1;
        r0 = rdcnt;
        expect_press(3'b001);
        press(3'b001);
        wait_idle(50);
        chk("t1_reads_l1", 32'(rdcnt[0] - r0[0]), 1);
        chk("t1_reads_l3", 32'(rdcnt[1] - r0[1]), 1);
        chk_pending();

        // single read of ADDR_B with a stalled consumer
        rdy1 = 1'b0; rdy3 = 1'b0;
        r0 = rdcnt;
        n = rp[0] + rp[1];
        expect_press(3'b010);
        press(3'b010);
        while (vld != 2'b11 && n < 1000) begin tick(1); n += 1000; end
        n = 0;
        while (vld != 2'b11 && n < 20) begin tick(1); n++; end
        if (vld != 2'b11) chk("t2_valid_timeout", 32'(vld), 3);
        n = rp[0];
        tick(5);
        chk("t2_no_accept", 32'(rp[0]), 32'(n));
        rdy1 = 1'b1; rdy3 = 1'b1;
        wait_idle(50);
        chk("t2_reads_l1", 32'(rdcnt[0] - r0[0]), 1);
        chk("t2_reads_l3", 32'(rdcnt[1] - r0[1]), 1);
        chk_pending();

        // full sweep; latency-3 consumer randomly throttled
        for (int i = 0; i < 256; i++) ram[i] = DW'(i + 'h10);
        thr_on = 1'b1;
        r0 = rdcnt; d0 = donecnt;
        acc_q.delete();
        rec_on = 1'b1;
        expect_press(3'b100);
        press(3'b100);
        wait_idle(600);
        rec_on = 1'b0;
        chk("t3_words", 32'(acc_q.size()), SWL);
        for (int i = 1; i < acc_q.size(); i++)
            chk("t3_rate", 32'(acc_q[i] - acc_q[i-1]), 3);
        chk("t3_done_l1", 32'(donecnt[0] - d0[0]), 1);
        chk("t3_done_l3", 32'(donecnt[1] - d0[1]), 1);
        chk("t3_reads_l1", 32'(rdcnt[0] - r0[0]), SWL);
        chk("t3_reads_l3", 32'(rdcnt[1] - r0[1]), SWL);
        chk_pending();

        // all three buttons at once: ADDR_A wins
        r0 = rdcnt;
        expect_press(3'b111);
        press(3'b111);
        wait_idle(100);
        chk("t4_reads_l1", 32'(rdcnt[0] - r0[0]), 1);
        chk("t4_reads_l3", 32'(rdcnt[1] - r0[1]), 1);
        chk_pending();

        // presses mid-sweep ignored; held button does not retrigger
        r0 = rdcnt;
        expect_press(3'b100);
        btn = 3'b011;
        tick(4);
        btn = 3'b111;
        tick(10);
        btn = 3'b100;
        tick(4);
        btn = 3'b110;
        wait_idle(600);
        tick(20);
        chk("t5_busy_held", 32'({busy3, busy1}), 0);
        chk("t5_reads_l1", 32'(rdcnt[0] - r0[0]), SWL);
        chk("t5_reads_l3", 32'(rdcnt[1] - r0[1]), SWL);
        chk_pending();
        btn = 3'b111;
        tick(5);
        expect_press(3'b001);
        press(3'b001);
        wait_idle(100);
        chk("t5_repress_l1", 32'(rdcnt[0] - r0[0]), SWL + 1);
        chk("t5_repress_l3", 32'(rdcnt[1] - r0[1]), SWL + 1);
        chk_pending();

        // reset while the latency-3 instance waits on a sweep read
        expect_press(3'b100);
        btn = 3'b011;
        tick(4);
        btn = 3'b111;
        n = 0;
        while (!rd[1] && n < 40) begin tick(1); n++; end
        if (!rd[1]) chk("t6_issue_timeout", 32'(rd), 2);
        tick(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs_zero("t6_rst");
        rp[0] = exp_w.size();
        rp[1] = exp_w.size();
        tick(2);
        rst_n = 1'b1;
        v0 = vcnt;
        tick(30);
        chk("t6_no_valid_l1", 32'(vcnt[0] - v0[0]), 0);
        chk("t6_no_valid_l3", 32'(vcnt[1] - v0[1]), 0);
        chk("t6_idle", 32'({busy3, busy1}), 0);
        expect_press(3'b010);
        press(3'b010);
        wait_idle(100);
        chk_pending();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
